// File: rtl/game_pkg.sv
// Types and defaults shared by the jump-input path, the game FSM and the display driver.
package game_pkg;
    localparam int PWR_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHARGE   = 2'd1,
        HOLD     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;
endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser + debouncer with 1-cycle rise/fall pulses; the first settle after reset
// loads the level without producing an edge.
module btn_debounce #(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEB_CNT > 1 ? DEB_CNT : 2);

    logic          s1, s2;
    logic          db_q;
    logic          settled;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            btn_db  <= 1'b0;
            db_q    <= 1'b0;
            settled <= 1'b0;
            cnt     <= '0;
        end else begin
            s1   <= btn_raw;
            s2   <= s1;
            db_q <= btn_db;
            if (!settled) begin
                // Track the synced level until it has been stable long enough, then arm edges.
                if (s2 != btn_db) begin
                    btn_db <= s2;
                    cnt    <= '0;
                end else if (cnt == CW'(DEB_CNT - 1)) begin
                    settled <= 1'b1;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (s2 != btn_db) begin
                if (cnt == CW'(DEB_CNT - 1)) begin
                    btn_db <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = settled &  btn_db & ~db_q;
    assign fall = settled & ~btn_db &  db_q;
endmodule

// File: rtl/press_power_capture.sv
// Measures jump-button hold time in ticks and hands it to the game FSM over valid/ready.
// Optional PRESS_TIMEOUT_EN: emit as soon as the level saturates, then wait for release.
module press_power_capture
    import game_pkg::*;
#(
    parameter int DEB_CNT  = 1_000_000,
    parameter int TICK_DIV = 100_000,
    parameter int PWR_W    = PWR_W_DEF,
    parameter int PWR_MAX  = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             enable,
    output logic [PWR_W-1:0] power,
    output logic             power_valid,
    input  logic             power_ready,
    output logic             charging,
    output logic [PWR_W-1:0] charge_level
);
    localparam int TW = $clog2(TICK_DIV > 1 ? TICK_DIV : 2);

    logic btn_db, rise, fall;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .btn_db  (btn_db),
        .rise    (rise),
        .fall    (fall)
    );

    state_t           state, nstate;
    logic [PWR_W-1:0] level, nlevel, level_inc;
    logic [TW-1:0]    tick, ntick;
    logic [PWR_W-1:0] npower;
    logic             nvalid;
    logic             wrap, at_max;
`ifdef PRESS_TIMEOUT_EN
    logic             timed_out, ntimed;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            level       <= '0;
            tick        <= '0;
            power       <= '0;
            power_valid <= 1'b0;
`ifdef PRESS_TIMEOUT_EN
            timed_out   <= 1'b0;
`endif
        end else begin
            state       <= nstate;
            level       <= nlevel;
            tick        <= ntick;
            power       <= npower;
            power_valid <= nvalid;
`ifdef PRESS_TIMEOUT_EN
            timed_out   <= ntimed;
`endif
        end
    end

    assign wrap      = (tick == TW'(TICK_DIV - 1));
    assign at_max    = (level == PWR_W'(PWR_MAX));
    assign level_inc = (wrap && !at_max) ? level + 1'b1 : level;

    always_comb begin
        nstate = state;
        nlevel = level;
        ntick  = tick;
        npower = power;
        nvalid = power_valid;
`ifdef PRESS_TIMEOUT_EN
        ntimed = timed_out;
`endif
        case (state)
            IDLE: begin
                if (rise && enable) begin
                    nstate = CHARGE;
                    nlevel = '0;
                    ntick  = '0;
                end
            end
            CHARGE: begin
                // Losing enable discards the press even if the release lands on the same cycle.
                if (!enable) begin
                    nstate = IDLE;
                end else begin
                    ntick  = wrap ? '0 : tick + 1'b1;
                    nlevel = level_inc;
                    if (fall) begin
                        if (level_inc != '0) begin
                            nstate = HOLD;
                            npower = level_inc;
                            nvalid = 1'b1;
                        end else begin
                            nstate = IDLE;
                        end
                    end
`ifdef PRESS_TIMEOUT_EN
                    else if (level_inc == PWR_W'(PWR_MAX)) begin
                        nstate = HOLD;
                        npower = PWR_W'(PWR_MAX);
                        nvalid = 1'b1;
                        ntimed = 1'b1;
                    end
`endif
                end
            end
            HOLD: begin
                if (power_valid && power_ready) begin
                    nvalid = 1'b0;
                    npower = '0;
                    nstate = IDLE;
`ifdef PRESS_TIMEOUT_EN
                    if (timed_out) begin
                        nstate = WAIT_REL;
                        ntimed = 1'b0;
                    end
`endif
                end
            end
            WAIT_REL: begin
                if (!btn_db) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    assign charging     = (state == CHARGE);
    assign charge_level = charging ? level : '0;
endmodule

// File: tb/tb_press_power_capture.sv
// Directed bench for press_power_capture with short debounce/tick parameters.
module tb_press_power_capture;
    localparam int DEB = 4;
    localparam int TD  = 10;
    localparam int PW  = 10;
    localparam int PM  = 15;

    logic          clk, rst, btn_raw, enable, power_ready;
    logic [PW-1:0] power, charge_level;
    logic          power_valid, charging;

    press_power_capture #(.DEB_CNT(DEB), .TICK_DIV(TD), .PWR_W(PW), .PWR_MAX(PM)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .enable       (enable),
        .power        (power),
        .power_valid  (power_valid),
        .power_ready  (power_ready),
        .charging     (charging),
        .charge_level (charge_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    int hs_pow = 0;
    int hs_held = 0;
    int chg_cnt = 0;

    always @(negedge clk) begin
        if (power_valid && power_ready) begin
            hs_cnt  = hs_cnt + 1;
            hs_pow  = int'(power);
            hs_held = int'(btn_raw);
        end
        if (charging) chg_cnt = chg_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        string nm;
        int    hold;
        bit    en;
        bit    exp_chg;
        int    exp_hs;
        int    exp_pow;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int h0, c0, found;
        vecs[0] = '{"clean57",  57, 1'b1, 1'b1, 1, 5};
        vecs[1] = '{"edge10",   10, 1'b1, 1'b1, 1, 1};
        vecs[2] = '{"tap9",      9, 1'b1, 1'b1, 0, 0};
        vecs[3] = '{"glitch3",   3, 1'b1, 1'b0, 0, 0};
        vecs[4] = '{"noenable", 57, 1'b0, 1'b0, 0, 0};
        vecs[5] = '{"t19",      19, 1'b1, 1'b1, 1, 1};
        vecs[6] = '{"t20",      20, 1'b1, 1'b1, 1, 2};

        rst = 1'b1; btn_raw = 1'b0; enable = 1'b1; power_ready = 1'b1;
        step(3);
        chk("rst_valid", int'(power_valid), 0);
        chk("rst_power", int'(power), 0);
        chk("rst_charging", int'(charging), 0);
        chk("rst_level", int'(charge_level), 0);
        rst = 1'b0;
        step(20);

        foreach (vecs[i]) begin
            h0 = hs_cnt; c0 = chg_cnt;
            enable  = vecs[i].en;
            btn_raw = 1'b1;
            step(vecs[i].hold);
            btn_raw = 1'b0;
            step(40);
            enable = 1'b1;
            chk({vecs[i].nm, "_chg"}, int'(chg_cnt != c0), int'(vecs[i].exp_chg));
            chk({vecs[i].nm, "_hs"}, hs_cnt - h0, vecs[i].exp_hs);
            if (vecs[i].exp_hs > 0) chk({vecs[i].nm, "_pow"}, hs_pow, vecs[i].exp_pow);
        end

        // Repeated short glitches never reach the debounced level.
        h0 = hs_cnt; c0 = chg_cnt;
        repeat (6) begin
            btn_raw = 1'b1; step(3);
            btn_raw = 1'b0; step(2);
        end
        step(20);
        chk("bounce_chg", chg_cnt - c0, 0);
        chk("bounce_hs", hs_cnt - h0, 0);

        // Backpressure: power=7 held stable until ready.
        power_ready = 1'b0;
        btn_raw = 1'b1; step(75); btn_raw = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(1);
            if (power_valid) found = 1;
        end
        chk("bp_valid_seen", found, 1);
        chk("bp_power", int'(power), 7);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("bp_hold_valid", int'(power_valid), 1);
            chk("bp_hold_power", int'(power), 7);
        end
        power_ready = 1'b1;
        step(1);
        chk("bp_clear_valid", int'(power_valid), 0);
        chk("bp_clear_power", int'(power), 0);
        step(10);

        // Long hold: saturation at PWR_MAX.
        h0 = hs_cnt;
        btn_raw = 1'b1;
        step(100);
        chk("long_charging", int'(charging), 1);
        chk("long_level9", int'(charge_level), 9);
        step(2900);
`ifdef PRESS_TIMEOUT_EN
        chk("long_early_hs", hs_cnt - h0, 1);
        chk("long_early_pow", hs_pow, PM);
        chk("long_early_held", hs_held, 1);
        chk("long_not_charging", int'(charging), 0);
        btn_raw = 1'b0;
        step(40);
        chk("long_no_second", hs_cnt - h0, 1);
`else
        chk("long_sat_level", int'(charge_level), PM);
        chk("long_no_early", hs_cnt - h0, 0);
        btn_raw = 1'b0;
        step(40);
        chk("long_hs", hs_cnt - h0, 1);
        chk("long_pow", hs_pow, PM);
`endif

        // Enable dropped mid-charge.
        h0 = hs_cnt;
        btn_raw = 1'b1; step(30);
        chk("en_drop_pre", int'(charging), 1);
        enable = 1'b0; step(1);
        chk("en_drop_idle", int'(charging), 0);
        step(44); btn_raw = 1'b0; step(30);
        enable = 1'b1;
        chk("en_drop_hs", hs_cnt - h0, 0);
        chk("en_drop_valid", int'(power_valid), 0);

        // Reset while power is pending discards it.
        power_ready = 1'b0;
        btn_raw = 1'b1; step(75); btn_raw = 1'b0;
        step(20);
        chk("rstmid_pending", int'(power_valid), 1);
        rst = 1'b1; step(1);
        chk("rstmid_valid", int'(power_valid), 0);
        chk("rstmid_power", int'(power), 0);
        rst = 1'b0; power_ready = 1'b1;
        step(20);

        // Button held through reset release never starts a charge.
        h0 = hs_cnt; c0 = chg_cnt;
        btn_raw = 1'b1; rst = 1'b1; step(3);
        rst = 1'b0; step(40);
        chk("held_rst_chg", chg_cnt - c0, 0);
        btn_raw = 1'b0; step(20);
        chk("held_rst_hs", hs_cnt - h0, 0);
        btn_raw = 1'b1; step(57); btn_raw = 1'b0; step(40);
        chk("held_rst_after_hs", hs_cnt - h0, 1);
        chk("held_rst_after_pow", hs_pow, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
